// File: rtl/bit_stream_tx_pkg.sv
// rtl/bit_stream_tx_pkg.sv - shared types and constants for the serial test-stream transmitter
package bit_stream_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_DONE = 2'd2
  } tx_state_t;

  // "101" tracker states; the detector checkers decode the same encoding.
  typedef enum logic [1:0] {
    TRK_T0 = 2'd0,
    TRK_T1 = 2'd1,
    TRK_T2 = 2'd2
  } trk_state_t;

  localparam logic IDLE_LINE = 1'b0;

endpackage

// File: rtl/bit_stream_tx_seq101_track.sv
// rtl/bit_stream_tx_seq101_track.sv - overlapping "101" tracker with saturating match counter
module seq101_track
  import bit_stream_tx_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic             match,
  output logic [CNT_W-1:0] count
);

  trk_state_t state, state_nxt;

  always_comb begin
    state_nxt = state;
    match     = 1'b0;
    if (en) begin
      case (state)
        TRK_T0: if (bit_in) state_nxt = TRK_T1;
        TRK_T1: if (!bit_in) state_nxt = TRK_T2;
        TRK_T2: begin
          // A completing 1 also starts the next candidate, so overlaps count.
          if (bit_in) begin
            state_nxt = TRK_T1;
            match     = 1'b1;
          end else begin
            state_nxt = TRK_T0;
          end
        end
        default: state_nxt = TRK_T0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TRK_T0;
      count <= '0;
    end else if (clr) begin
      state <= TRK_T0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (match && (count != {CNT_W{1'b1}})) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bit_stream_tx.sv
// rtl/bit_stream_tx.sv - parallel word in, MSB-first serial line out with "101" match tracking
module bit_stream_tx
  import bit_stream_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             m_out,
  output logic             bit_strobe,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);

  tx_state_t        state, state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             accept;
  logic             div_last;
  logic             last_bit;

  assign div_last = (div_cnt == DIV_W'(DIV - 1));
  assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    m_out      = IDLE_LINE;
    bit_strobe = 1'b0;
    accept     = 1'b0;
    case (state)
      TX_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          accept    = 1'b1;
          state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        busy       = 1'b1;
        m_out      = shift_reg[WIDTH-1];
        bit_strobe = (div_cnt == '0);
        if (div_last && last_bit) state_nxt = TX_DONE;
      end
      TX_DONE: begin
        done      = 1'b1;
        state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      shift_reg <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shift_reg <= data_in;
        div_cnt   <= '0;
        bit_cnt   <= '0;
      end else if (state == TX_SEND) begin
        if (div_last) begin
          div_cnt   <= '0;
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  // History is wiped on acceptance so matches never span words.
  seq101_track #(
    .CNT_W(CNT_W)
  ) u_track (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (bit_strobe),
    .bit_in(m_out),
    .match (match),
    .count (match_cnt)
  );

endmodule
